// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
package riscv_ctrl_pkg;

    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT3_W   = 3;
    localparam int unsigned STATE_W    = 2;
    localparam int unsigned WB_SEL_W   = 2;
    localparam int unsigned BYTE_LANES = 4;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_FENCE  = 7'b0001111;
    localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

    localparam logic [STATE_W-1:0] S_FETCH  = 2'd0;
    localparam logic [STATE_W-1:0] S_DECODE = 2'd1;
    localparam logic [STATE_W-1:0] S_EXEC   = 2'd2;
    localparam logic [STATE_W-1:0] S_WB     = 2'd3;

    localparam logic [WB_SEL_W-1:0] WB_ALU = 2'b00;
    localparam logic [WB_SEL_W-1:0] WB_MEM = 2'b01;
    localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'b10;
    localparam logic [WB_SEL_W-1:0] WB_IMM = 2'b11;

endpackage

// File: rtl/riscv_main_decoder.sv
// Opcode/funct3 decode: level selects plus ungated memory and register-file requests.
module riscv_main_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [FUNCT3_W-1:0]   funct3,
    output logic                  branch,
    output logic                  jump,
    output logic                  pc_src,
    output logic                  alu_src,
    output logic [WB_SEL_W-1:0]   mem_to_reg,
    output logic                  mem_read_req,
    output logic                  reg_write_req,
    output logic [BYTE_LANES-1:0] mem_write_req
);

    always_comb begin
        branch        = 1'b0;
        jump          = 1'b0;
        pc_src        = 1'b0;
        alu_src       = 1'b0;
        mem_to_reg    = WB_ALU;
        mem_read_req  = 1'b0;
        reg_write_req = 1'b0;
        mem_write_req = '0;
        case (opcode)
            OP_R: begin
                reg_write_req = 1'b1;
            end
            OP_IMM, OP_AUIPC: begin
                alu_src       = 1'b1;
                reg_write_req = 1'b1;
            end
            OP_LOAD: begin
                alu_src       = 1'b1;
                mem_to_reg    = WB_MEM;
                mem_read_req  = 1'b1;
                reg_write_req = 1'b1;
            end
            OP_STORE: begin
                alu_src = 1'b1;
                // Byte-lane mask for SB/SH/SW; other widths write nothing
                case (funct3)
                    3'b000:  mem_write_req = 4'b0001;
                    3'b001:  mem_write_req = 4'b0011;
                    3'b010:  mem_write_req = 4'b1111;
                    default: mem_write_req = 4'b0000;
                endcase
            end
            OP_BRANCH: begin
                branch = 1'b1;
            end
            OP_JAL: begin
                jump          = 1'b1;
                mem_to_reg    = WB_PC4;
                reg_write_req = 1'b1;
            end
            OP_JALR: begin
                jump          = 1'b1;
                pc_src        = 1'b1;
                alu_src       = 1'b1;
                mem_to_reg    = WB_PC4;
                reg_write_req = 1'b1;
            end
            OP_LUI: begin
                alu_src       = 1'b1;
                mem_to_reg    = WB_IMM;
                reg_write_req = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/riscv_control_unit.sv
// Four-phase instruction sequencer gating decoder requests to the right phase.
module riscv_control_unit
    import riscv_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [FUNCT3_W-1:0]   funct3,
    output logic                  Branch,
    output logic                  Jump,
    output logic                  MemRead,
    output logic [WB_SEL_W-1:0]   MemtoReg,
    output logic [BYTE_LANES-1:0] MemWrite,
    output logic                  PCsrc,
    output logic                  ALUSrc,
    output logic                  RegWrite,
    output logic                  pc_en
);

    logic [STATE_W-1:0]    state;
    logic [STATE_W-1:0]    next_state;
    logic                  dec_branch;
    logic                  dec_jump;
    logic                  dec_pc_src;
    logic                  dec_alu_src;
    logic [WB_SEL_W-1:0]   dec_mem_to_reg;
    logic                  dec_mem_read;
    logic                  dec_reg_write;
    logic [BYTE_LANES-1:0] dec_mem_write;

    riscv_main_decoder u_decoder (
        .opcode        (opcode),
        .funct3        (funct3),
        .branch        (dec_branch),
        .jump          (dec_jump),
        .pc_src        (dec_pc_src),
        .alu_src       (dec_alu_src),
        .mem_to_reg    (dec_mem_to_reg),
        .mem_read_req  (dec_mem_read),
        .reg_write_req (dec_reg_write),
        .mem_write_req (dec_mem_write)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are held at zero while rst is asserted so no strobe can glitch
    always_comb begin
        next_state = STATE_W'(state + 1'b1);
        Branch     = 1'b0;
        Jump       = 1'b0;
        MemRead    = 1'b0;
        MemtoReg   = WB_ALU;
        MemWrite   = '0;
        PCsrc      = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        pc_en      = 1'b0;
        if (!rst) begin
            Branch   = dec_branch;
            Jump     = dec_jump;
            MemtoReg = dec_mem_to_reg;
            PCsrc    = dec_pc_src;
            ALUSrc   = dec_alu_src;
            case (state)
                S_FETCH, S_DECODE: begin
                end
                S_EXEC: begin
                    MemRead  = dec_mem_read;
                    MemWrite = dec_mem_write;
                end
                S_WB: begin
                    RegWrite = dec_reg_write;
                    pc_en    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_control_unit.sv
// Randomized and directed checks of the control unit against a phase-counting reference model.
module tb_riscv_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       Branch, Jump, MemRead, PCsrc, ALUSrc, RegWrite, pc_en;
    logic [1:0] MemtoReg;
    logic [3:0] MemWrite;

    int checks = 0;
    int fails  = 0;
    int phase  = 0;
    int pc_en_seen = 0;
    int instr_done = 0;

    riscv_control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .funct3   (funct3),
        .Branch   (Branch),
        .Jump     (Jump),
        .MemRead  (MemRead),
        .MemtoReg (MemtoReg),
        .MemWrite (MemWrite),
        .PCsrc    (PCsrc),
        .ALUSrc   (ALUSrc),
        .RegWrite (RegWrite),
        .pc_en    (pc_en)
    );

    always #5 clk = ~clk;

    // Position within the current instruction: 0 fetch .. 3 writeback
    always @(posedge clk or posedge rst) begin
        if (rst) phase <= 0;
        else     phase <= (phase + 1) % 4;
    end

    // Packed as {Branch, Jump, MemRead, MemtoReg, MemWrite, PCsrc, ALUSrc, RegWrite, pc_en}
    function automatic logic [12:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input int ph, input logic r);
        logic       br, jp, mr, pcs, asrc, rw, pe, writes_rd;
        logic [1:0] wb;
        logic [3:0] mw;
        br = 0; jp = 0; mr = 0; pcs = 0; asrc = 0; rw = 0; pe = 0; writes_rd = 0;
        wb = 2'b00; mw = 4'b0000;
        if (r) return 13'b0;
        writes_rd = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
                    (op == 7'b1101111) || (op == 7'b1100111) || (op == 7'b0110111) ||
                    (op == 7'b0010111);
        asrc = (op == 7'b0010011) || (op == 7'b0000011) || (op == 7'b0100011) ||
               (op == 7'b1100111) || (op == 7'b0110111) || (op == 7'b0010111);
        br  = (op == 7'b1100011);
        jp  = (op == 7'b1101111) || (op == 7'b1100111);
        pcs = (op == 7'b1100111);
        if (op == 7'b0000011) wb = 2'b01;
        else if (jp)          wb = 2'b10;
        else if (op == 7'b0110111) wb = 2'b11;
        if (ph == 2) begin
            mr = (op == 7'b0000011);
            if (op == 7'b0100011) begin
                if (f3 == 3'd0)      mw = 4'b0001;
                else if (f3 == 3'd1) mw = 4'b0011;
                else if (f3 == 3'd2) mw = 4'b1111;
            end
        end
        if (ph == 3) begin
            rw = writes_rd;
            pe = 1'b1;
        end
        return {br, jp, mr, wb, mw, pcs, asrc, rw, pe};
    endfunction

    function automatic logic [12:0] actual();
        return {Branch, Jump, MemRead, MemtoReg, MemWrite, PCsrc, ALUSrc, RegWrite, pc_en};
    endfunction

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (op=%b f3=%b phase=%0d rst=%b)",
                     name, act, exp, opcode, funct3, phase, rst);
        end
    endtask

    always @(negedge clk) begin
        chk("model", actual(), model(opcode, funct3, phase, rst));
        if (pc_en === 1'b1) pc_en_seen++;
    end

    // Directed instruction with literal expectations; entered just after the FETCH edge
    task automatic lit_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic [1:0] e_wb, input logic e_asrc,
                             input logic [3:0] e_mw, input logic e_mr, input logic e_rw);
        opcode = op;
        funct3 = f3;
        @(negedge clk);
        chk("fetch_sel", 13'({MemtoReg, ALUSrc}), 13'({e_wb, e_asrc}));
        chk("fetch_strobes", 13'({MemRead, MemWrite, RegWrite, pc_en}), 13'b0);
        @(negedge clk);
        @(negedge clk);
        chk("exec_mem", 13'({MemWrite, MemRead}), 13'({e_mw, e_mr}));
        @(negedge clk);
        chk("wb_strobes", 13'({RegWrite, pc_en, MemWrite}), 13'({e_rw, 1'b1, 4'b0000}));
        @(posedge clk);
        #2;
        instr_done++;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
        repeat (4) @(posedge clk);
        #2;
        instr_done++;
    endtask

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
                             7'b1110011};

    initial begin
        #1;
        chk("reset_outputs", actual(), 13'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Store SW interrupted in EXECUTE
        opcode = 7'b0100011;
        funct3 = 3'b010;
        repeat (3) @(negedge clk);
        chk("store_exec_pre_rst", 13'(MemWrite), 13'b1111);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_zero", actual(), 13'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        lit_instr(7'b0100011, 3'b010, 2'b00, 1'b1, 4'b1111, 1'b0, 1'b0);

        lit_instr(7'b0110011, 3'b000, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b1);
        lit_instr(7'b0000011, 3'b010, 2'b01, 1'b1, 4'b0000, 1'b1, 1'b1);
        for (int f = 0; f < 4; f++) begin
            logic [3:0] mws [4] = '{4'b0001, 4'b0011, 4'b1111, 4'b0000};
            lit_instr(7'b0100011, 3'(f), 2'b00, 1'b1, mws[f], 1'b0, 1'b0);
        end
        opcode = 7'b1100111;
        #1;
        chk("jalr_levels", 13'({Jump, PCsrc, MemtoReg, Branch}), 13'b11100);
        lit_instr(7'b1100111, 3'b000, 2'b10, 1'b1, 4'b0000, 1'b0, 1'b1);
        opcode = 7'b1101111;
        #1;
        chk("jal_levels", 13'({Jump, PCsrc, MemtoReg}), 13'b1010);
        lit_instr(7'b1101111, 3'b000, 2'b10, 1'b0, 4'b0000, 1'b0, 1'b1);
        opcode = 7'b1100011;
        #1;
        chk("branch_levels", 13'({Branch, Jump}), 13'b10);
        lit_instr(7'b1100011, 3'b001, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        lit_instr(7'b0110111, 3'b000, 2'b11, 1'b1, 4'b0000, 1'b0, 1'b1);
        lit_instr(7'b0010111, 3'b000, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1);
        lit_instr(7'b0001111, 3'b000, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);
        lit_instr(7'b1110011, 3'b000, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b0);

        // Random traffic with occasional mid-instruction resets
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
            f3 = 3'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                int k;
                k = $urandom_range(0, 3);
                opcode = op;
                funct3 = f3;
                repeat (k) @(posedge clk);
                #1;
                rst = 1'b1;
                #1;
                chk("rand_rst_zero", actual(), 13'b0);
                @(posedge clk);
                #2;
                rst = 1'b0;
            end else begin
                run_instr(op, f3);
            end
        end

        checks++;
        if (pc_en_seen != instr_done) begin
            fails++;
            $display("FAIL pc_en_count: got %0d pulses expected %0d", pc_en_seen, instr_done);
        end
        if (checks < 12) begin
            fails++;
            $display("FAIL check_count: got %0d expected at least 12", checks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
